system_clkgen_mc: RTL and testbench
===================================

// Module: system_clkgen_mc
// PURPOSE
//  Parametrised multi-channel clock generator. Divides refclk into NUM_CLOCKS
//  phase-aligned output clocks, each with runtime-programmable period, high
//  time and phase offset, plus a lock indication. It sits beside system_pll_0:
//  the PLL supplies refclk, and this block derives per-channel ultrasound
//  TX/ADC clocks.
// PARAMETERS
//  NUM_CLOCKS   4    number of output channels (1..16)
//  DIV_W        16   width of the div, high and phase registers
//  DEF_DIV      25   reset period in refclk cycles (2 MHz from 50 MHz)
//  LOCK_CYCLES  16   refclk cycles from apply to locked (>=2)
// PORTS
//  refclk      in   1                 reference clock; all logic on its rising edge
//  rst         in   1                 asynchronous, active-high reset
//  cfg_wr      in   1                 1-cycle write strobe to the shadow registers
//  cfg_sel     in   2                 0=div, 1=high, 2=phase; 3=ignored
//  cfg_ch      in   clog2(NUM_CLOCKS) channel index; if >=NUM_CLOCKS the write is dropped
//  cfg_data    in   DIV_W             write data
//  cfg_apply   in   1                 1-cycle strobe: shadow->active, realign all channels
//  outclk_en   in   NUM_CLOCKS        per-channel output gate
//  phase_step  in   1                 dynamic phase step strobe (DYN_PHASE_EN)
//  phase_updn  in   1                 1=delay one cycle, 0=advance one cycle
//  phase_ch    in   clog2(NUM_CLOCKS) channel to step
//  outclk      out  NUM_CLOCKS        registered output clocks
//  outclk_stb  out  NUM_CLOCKS        1-cycle pulse on the cycle outclk[i] goes 0->1
//  locked      out  1                 all channels aligned and stable
//  phase_done  out  1                 1-cycle acknowledge of phase_step
// BEHAVIOUR
//  - Reset: outclk, outclk_stb, locked and phase_done = 0. Shadow and active
//    registers: div=DEF_DIV, high=DEF_DIV/2, phase=0. FSM enters ALIGN.
//  - Sanitising at apply: div<2 -> 2. high=0 -> 1. high>=div -> div-1.
//    phase>=div -> div-1. Shadow registers keep the raw values.
//  - FSM states:
//    - ALIGN (1 cycle): load the active registers and set cnt[i]=(div-phase)%div
//      for every channel. Then go to WAIT.
//    - WAIT: count LOCK_CYCLES-1 cycles, then go to LOCKED. locked=1 from the
//      edge LOCK_CYCLES after the ALIGN edge.
//    - LOCKED: stay until cfg_apply.
//    - cfg_apply in any state -> ALIGN. locked drops on the same edge, and the
//      lock count restarts.
//  - Counter per channel: cnt wraps div-1 -> 0.
//    - outclk[i] <= outclk_en[i] & (cnt[i] < high[i]), registered.
//    - Latency is 1 cycle from cnt to the pin. The channel's first rising edge
//      comes phase cycles after alignment.
//  - outclk_en low: outclk[i] is forced 0 but cnt keeps running, so re-enable
//    is phase-coherent. outclk_stb[i] is suppressed while the channel is gated.
//  - cfg_wr and cfg_apply in the same cycle: the write lands first and is
//    included in the apply (write-through).
//  - Writes while WAIT or LOCKED do not affect the outputs until the next apply.
//  - rst asserted mid-operation clears everything immediately. There is no
//    partial-period completion.
// CONFIGURATION
//  DYN_PHASE_EN defined:
//    - phase_step sampled high: cnt[phase_ch] holds one cycle (updn=1, delay)
//      or skips one count (updn=0, advance).
//    - phase_done pulses on the next cycle. locked is unaffected.
//    - A step is ignored while in ALIGN or WAIT, and phase_done still pulses.
//    - Steps to an out-of-range phase_ch are ignored, and phase_done still pulses.
//  DYN_PHASE_EN undefined: phase_step, phase_updn and phase_ch are ignored;
//    phase_done is tied 0. The port list is unchanged.
// TESTING
//  - Reset release, no writes: all outclk 12 cycles high / 13 low (period 25).
//    locked=1 exactly 16 cycles after the first ALIGN. All channels edge-aligned.
//  - ch1 div=10, high=3, phase=4, then apply: ch1 rises 4+1 cycles after ALIGN,
//    period 10, high 3. Other channels realign, and locked drops then
//    reasserts after 16 cycles.
//  - Clamping: ch0 div=1, high=0, phase=7, then apply: period 2, high 1,
//    phase 1. A write with cfg_ch=5 (NUM_CLOCKS=4) changes nothing.
//  - Same-cycle cfg_wr(div=8, ch2) and cfg_apply: ch2 runs at period 8 from
//    that apply.
//  - Gate ch3 low for 37 cycles, then high: outclk[3] stays 0 with no stb
//    while gated, and its edges land on the ungated 25-cycle grid.
//  - DYN_PHASE_EN: three phase_step strobes with updn=1 on ch0 while LOCKED:
//    ch0 rising edge moves +3 cycles and three phase_done pulses appear.
//    Assert rst mid-period: all outputs are 0 asynchronously.

Source files
------------

// File: rtl/system_clkgen_mc.sv
// Multi-channel refclk divider: per-channel programmable period/high/phase, realign on apply, lock flag.
// Optional dynamic phase stepping is compiled in when the macro DYN_PHASE_EN is defined.
module system_clkgen_mc #(
    parameter int  NUM_CLOCKS  = 4,
    parameter int  DIV_W       = 16,
    parameter int  DEF_DIV     = 25,
    parameter int  LOCK_CYCLES = 16,
    // Channel selects carry one code beyond NUM_CLOCKS-1 so an out-of-range index is expressible.
    localparam int CH_W        = $clog2(NUM_CLOCKS + 1),
    localparam int LK_W        = $clog2(LOCK_CYCLES)
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  cfg_wr,
    input  logic [1:0]            cfg_sel,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [DIV_W-1:0]      cfg_data,
    input  logic                  cfg_apply,
    input  logic [NUM_CLOCKS-1:0] outclk_en,
    input  logic                  phase_step,
    input  logic                  phase_updn,
    input  logic [CH_W-1:0]       phase_ch,
    output logic [NUM_CLOCKS-1:0] outclk,
    output logic [NUM_CLOCKS-1:0] outclk_stb,
    output logic                  locked,
    output logic                  phase_done
);

    typedef enum logic [1:0] {ST_ALIGN, ST_WAIT, ST_LOCKED} state_t;

    state_t                state;
    logic [LK_W-1:0]       lock_cnt;
    logic [DIV_W-1:0]      sh_div    [NUM_CLOCKS];
    logic [DIV_W-1:0]      sh_high   [NUM_CLOCKS];
    logic [DIV_W-1:0]      sh_phase  [NUM_CLOCKS];
    logic [DIV_W-1:0]      act_div   [NUM_CLOCKS];
    logic [DIV_W-1:0]      act_high  [NUM_CLOCKS];
    logic [DIV_W-1:0]      cnt       [NUM_CLOCKS];
    logic [DIV_W-1:0]      san_div   [NUM_CLOCKS];
    logic [DIV_W-1:0]      san_high  [NUM_CLOCKS];
    logic [DIV_W-1:0]      san_phase [NUM_CLOCKS];
    logic [DIV_W-1:0]      san_start [NUM_CLOCKS];
    logic [1:0]            cnt_inc   [NUM_CLOCKS];
    logic [DIV_W:0]        cnt_sum   [NUM_CLOCKS];
    logic [DIV_W-1:0]      cnt_nxt   [NUM_CLOCKS];
    logic [NUM_CLOCKS-1:0] clk_hi;

    // NOTE: configuration arrays are real registers with defined reset values, not scratch memory.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                sh_div[i]   <= DIV_W'(DEF_DIV);
                sh_high[i]  <= DIV_W'(DEF_DIV / 2);
                sh_phase[i] <= '0;
            end
        end else if (cfg_wr) begin
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                if (cfg_ch == CH_W'(i)) begin
                    case (cfg_sel)
                        2'd0:    sh_div[i]   <= cfg_data;
                        2'd1:    sh_high[i]  <= cfg_data;
                        2'd2:    sh_phase[i] <= cfg_data;
                        default: ;
                    endcase
                end
            end
        end
    end

    // NOTE: each always_comb output is assigned a default before any condition, so no latch appears.
    always_comb begin
        for (int i = 0; i < NUM_CLOCKS; i++) begin
            san_div[i]   = sh_div[i];
            san_high[i]  = sh_high[i];
            san_phase[i] = sh_phase[i];
            if (sh_div[i] < DIV_W'(2))
                san_div[i] = DIV_W'(2);
            if (sh_high[i] == '0)
                san_high[i] = DIV_W'(1);
            if (san_high[i] >= san_div[i])
                san_high[i] = san_div[i] - DIV_W'(1);
            if (san_phase[i] >= san_div[i])
                san_phase[i] = san_div[i] - DIV_W'(1);
            // Start value (div-phase) mod div, so the count reaches 0 exactly phase cycles after ALIGN.
            san_start[i] = (san_phase[i] == '0) ? '0 : san_div[i] - san_phase[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CLOCKS; i++) begin
            cnt_inc[i] = 2'd1;
`ifdef DYN_PHASE_EN
            if (phase_step && state == ST_LOCKED && phase_ch == CH_W'(i))
                cnt_inc[i] = phase_updn ? 2'd0 : 2'd2;
`endif
            cnt_sum[i] = {1'b0, cnt[i]} + (DIV_W + 1)'(cnt_inc[i]);
            cnt_nxt[i] = (cnt_sum[i] >= {1'b0, act_div[i]}) ?
                         DIV_W'(cnt_sum[i] - {1'b0, act_div[i]}) : DIV_W'(cnt_sum[i]);
            clk_hi[i]  = outclk_en[i] && (cnt[i] < act_high[i]);
        end
    end

    // NOTE: all sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state      <= ST_ALIGN;
            lock_cnt   <= '0;
            locked     <= 1'b0;
            outclk     <= '0;
            outclk_stb <= '0;
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                act_div[i]  <= DIV_W'(DEF_DIV);
                act_high[i] <= DIV_W'(DEF_DIV / 2);
                cnt[i]      <= '0;
            end
        end else begin
            if (state == ST_ALIGN) begin
                for (int i = 0; i < NUM_CLOCKS; i++) begin
                    act_div[i]  <= san_div[i];
                    act_high[i] <= san_high[i];
                    cnt[i]      <= san_start[i];
                end
                outclk     <= '0;
                outclk_stb <= '0;
                lock_cnt   <= '0;
                state      <= ST_WAIT;
            end else begin
                for (int i = 0; i < NUM_CLOCKS; i++)
                    cnt[i] <= cnt_nxt[i];
                outclk     <= clk_hi;
                outclk_stb <= clk_hi & ~outclk;
                if (state == ST_WAIT) begin
                    if (lock_cnt == LK_W'(LOCK_CYCLES - 1)) begin
                        state  <= ST_LOCKED;
                        locked <= 1'b1;
                    end else begin
                        lock_cnt <= lock_cnt + LK_W'(1);
                    end
                end
            end
            if (cfg_apply) begin
                state  <= ST_ALIGN;
                locked <= 1'b0;
            end
        end
    end

`ifdef DYN_PHASE_EN
    always_ff @(posedge refclk or posedge rst) begin
        if (rst)
            phase_done <= 1'b0;
        else
            phase_done <= phase_step;
    end
`else
    logic unused_phase;
    assign unused_phase = ^{phase_step, phase_updn, phase_ch};
    assign phase_done   = 1'b0;
`endif

endmodule

// File: tb/tb_system_clkgen_mc.sv
// Directed self-checking bench for system_clkgen_mc: reset waveform, programming, clamping,
// write-through apply, gating, phase stepping and asynchronous reset.
module tb_system_clkgen_mc;

    localparam int NC = 4;
    localparam int DW = 16;
    localparam int CW = 3;
    localparam int TN = 110;
`ifdef DYN_PHASE_EN
    localparam bit DYN = 1'b1;
`else
    localparam bit DYN = 1'b0;
`endif

    logic          refclk = 1'b0;
    logic          rst;
    logic          cfg_wr, cfg_apply;
    logic [1:0]    cfg_sel;
    logic [CW-1:0] cfg_ch;
    logic [DW-1:0] cfg_data;
    logic [NC-1:0] outclk_en;
    logic          phase_step, phase_updn;
    logic [CW-1:0] phase_ch;
    logic [NC-1:0] outclk, outclk_stb;
    logic          locked, phase_done;

    int checks = 0;
    int errors = 0;

    // Traces indexed by j = edges since the ALIGN edge (j=0 is the ALIGN edge itself).
    logic [NC-1:0] tr_out  [TN];
    logic [NC-1:0] tr_stb  [TN];
    logic          tr_lk   [TN];
    logic          tr_done [TN];
    logic [NC-1:0] en_sched   [TN];
    logic          step_sched [TN];
    logic [CW-1:0] stepch_sched [TN];
    logic          updn_sched;
    logic          lk_pre;
    int            m_div [NC];
    int            m_high[NC];
    int            m_phase[NC];

    always #5 refclk = ~refclk;

    system_clkgen_mc dut (
        .refclk     (refclk),
        .rst        (rst),
        .cfg_wr     (cfg_wr),
        .cfg_sel    (cfg_sel),
        .cfg_ch     (cfg_ch),
        .cfg_data   (cfg_data),
        .cfg_apply  (cfg_apply),
        .outclk_en  (outclk_en),
        .phase_step (phase_step),
        .phase_updn (phase_updn),
        .phase_ch   (phase_ch),
        .outclk     (outclk),
        .outclk_stb (outclk_stb),
        .locked     (locked),
        .phase_done (phase_done)
    );

    // Expected outclk bit of channel c after edge j for an ungated-phase-step channel.
    function automatic logic exp_bit(int c, int j);
        int start;
        if (j < 1 || !en_sched[j][c]) return 1'b0;
        start = (m_phase[c] == 0) ? 0 : m_div[c] - m_phase[c];
        return ((start + j - 1) % m_div[c]) < m_high[c];
    endfunction

    task automatic set_model(int c, int d, int h, int p);
        m_div[c] = d; m_high[c] = h; m_phase[c] = p;
    endtask

    task automatic clear_sched();
        for (int i = 0; i < TN; i++) begin
            en_sched[i] = '1; step_sched[i] = 1'b0; stepch_sched[i] = '0;
        end
        updn_sched = 1'b1;
    endtask

    task automatic drive_for(int i);
        outclk_en  = en_sched[i];
        phase_step = step_sched[i];
        phase_ch   = stepch_sched[i];
        phase_updn = updn_sched;
    endtask

    task automatic cfg_write(logic [1:0] sel, logic [CW-1:0] ch, logic [DW-1:0] data);
        cfg_wr = 1'b1; cfg_sel = sel; cfg_ch = ch; cfg_data = data;
        @(negedge refclk);
        cfg_wr = 1'b0;
    endtask

    task automatic capture(int n, bit with_apply);
        if (with_apply) begin
            cfg_apply = 1'b1;
            @(negedge refclk);
            cfg_apply = 1'b0;
            cfg_wr    = 1'b0;
            lk_pre    = locked;
        end
        drive_for(0);
        for (int i = 0; i < n; i++) begin
            @(negedge refclk);
            tr_out[i]  = outclk;
            tr_stb[i]  = outclk_stb;
            tr_lk[i]   = locked;
            tr_done[i] = phase_done;
            if (i + 1 < TN) drive_for(i + 1);
        end
        phase_step = 1'b0;
        outclk_en  = '1;
    endtask

    task automatic test_reset();
        logic s;
        repeat (3) @(negedge refclk);
        checks++;
        if (outclk !== '0 || outclk_stb !== '0 || locked !== 1'b0 || phase_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold got out=%b stb=%b lk=%b done=%b want all 0",
                     outclk, outclk_stb, locked, phase_done);
        end
        for (int c = 0; c < NC; c++) set_model(c, 25, 12, 0);
        clear_sched();
        rst = 1'b0;
        capture(60, 1'b0);
        for (int j = 0; j < 60; j++) begin
            for (int c = 0; c < NC; c++) begin
                checks++;
                if (tr_out[j][c] !== exp_bit(c, j)) begin
                    errors++;
                    $display("FAIL reset_wave j=%0d ch=%0d got %b want %b", j, c, tr_out[j][c], exp_bit(c, j));
                end
                s = (j >= 1) && exp_bit(c, j) && !exp_bit(c, j - 1);
                checks++;
                if (tr_stb[j][c] !== s) begin
                    errors++;
                    $display("FAIL reset_stb j=%0d ch=%0d got %b want %b", j, c, tr_stb[j][c], s);
                end
            end
            checks++;
            if (tr_lk[j] !== (j >= 16)) begin
                errors++;
                $display("FAIL reset_locked j=%0d got %b want %b", j, tr_lk[j], (j >= 16));
            end
        end
        checks++;
        if (tr_out[12] !== 4'hF || tr_out[13] !== 4'h0 || tr_out[26] !== 4'hF) begin
            errors++;
            $display("FAIL reset_12_13 got %h %h %h want f 0 f", tr_out[12], tr_out[13], tr_out[26]);
        end
    endtask

    task automatic test_program();
        cfg_write(2'd0, 3'd1, 16'd10);
        cfg_write(2'd1, 3'd1, 16'd3);
        cfg_write(2'd2, 3'd1, 16'd4);
        checks++;
        if (locked !== 1'b1 || outclk[1] !== outclk[0]) begin
            errors++;
            $display("FAIL program_preapply got lk=%b out=%b want lk=1 ch1==ch0", locked, outclk);
        end
        set_model(1, 10, 3, 4);
        capture(40, 1'b1);
        checks++;
        if (lk_pre !== 1'b0) begin
            errors++;
            $display("FAIL program_lock_drop got %b want 0", lk_pre);
        end
        for (int j = 0; j < 40; j++) begin
            for (int c = 0; c < NC; c++) begin
                checks++;
                if (tr_out[j][c] !== exp_bit(c, j)) begin
                    errors++;
                    $display("FAIL program_wave j=%0d ch=%0d got %b want %b", j, c, tr_out[j][c], exp_bit(c, j));
                end
            end
            checks++;
            if (tr_lk[j] !== (j >= 16)) begin
                errors++;
                $display("FAIL program_locked j=%0d got %b want %b", j, tr_lk[j], (j >= 16));
            end
        end
        checks++;
        if (tr_out[4][1] !== 1'b0 || tr_out[5][1] !== 1'b1 || tr_out[8][1] !== 1'b0 ||
            tr_out[15][1] !== 1'b1 || tr_stb[5][1] !== 1'b1 || tr_stb[15][1] !== 1'b1) begin
            errors++;
            $display("FAIL program_ch1_edges got o4=%b o5=%b o8=%b o15=%b s5=%b s15=%b want 0 1 0 1 1 1",
                     tr_out[4][1], tr_out[5][1], tr_out[8][1], tr_out[15][1], tr_stb[5][1], tr_stb[15][1]);
        end
    endtask

    task automatic test_clamp();
        cfg_write(2'd0, 3'd0, 16'd1);
        cfg_write(2'd1, 3'd0, 16'd0);
        cfg_write(2'd2, 3'd0, 16'd7);
        cfg_write(2'd0, 3'd5, 16'd3);
        cfg_write(2'd1, 3'd5, 16'd9);
        set_model(0, 2, 1, 1);
        capture(30, 1'b1);
        for (int j = 0; j < 30; j++) begin
            for (int c = 0; c < NC; c++) begin
                checks++;
                if (tr_out[j][c] !== exp_bit(c, j)) begin
                    errors++;
                    $display("FAIL clamp_wave j=%0d ch=%0d got %b want %b", j, c, tr_out[j][c], exp_bit(c, j));
                end
            end
        end
        checks++;
        if (tr_out[1][0] !== 1'b0 || tr_out[2][0] !== 1'b1 || tr_out[3][0] !== 1'b0 || tr_out[4][0] !== 1'b1) begin
            errors++;
            $display("FAIL clamp_ch0 got %b%b%b%b want 0101", tr_out[1][0], tr_out[2][0], tr_out[3][0], tr_out[4][0]);
        end
    endtask

    task automatic test_write_through();
        cfg_wr = 1'b1; cfg_sel = 2'd0; cfg_ch = 3'd2; cfg_data = 16'd8;
        set_model(2, 8, 7, 0);
        capture(30, 1'b1);
        for (int j = 0; j < 30; j++) begin
            for (int c = 0; c < NC; c++) begin
                checks++;
                if (tr_out[j][c] !== exp_bit(c, j)) begin
                    errors++;
                    $display("FAIL wt_wave j=%0d ch=%0d got %b want %b", j, c, tr_out[j][c], exp_bit(c, j));
                end
            end
        end
        checks++;
        if (tr_out[8][2] !== 1'b0 || tr_out[9][2] !== 1'b1 || tr_out[7][2] !== 1'b1) begin
            errors++;
            $display("FAIL wt_ch2 got o7=%b o8=%b o9=%b want 1 0 1", tr_out[7][2], tr_out[8][2], tr_out[9][2]);
        end
    endtask

    task automatic test_gate();
        logic s;
        clear_sched();
        for (int j = 30; j < 67; j++) en_sched[j][3] = 1'b0;
        capture(100, 1'b1);
        for (int j = 0; j < 100; j++) begin
            for (int c = 0; c < NC; c++) begin
                checks++;
                if (tr_out[j][c] !== exp_bit(c, j)) begin
                    errors++;
                    $display("FAIL gate_wave j=%0d ch=%0d got %b want %b", j, c, tr_out[j][c], exp_bit(c, j));
                end
            end
            s = (j >= 1) && exp_bit(3, j) && !exp_bit(3, j - 1);
            checks++;
            if (tr_stb[j][3] !== s) begin
                errors++;
                $display("FAIL gate_stb j=%0d got %b want %b", j, tr_stb[j][3], s);
            end
        end
        checks++;
        if (tr_out[67][3] !== 1'b0 || tr_out[75][3] !== 1'b0 || tr_out[76][3] !== 1'b1 || tr_stb[76][3] !== 1'b1) begin
            errors++;
            $display("FAIL gate_regrid got o67=%b o75=%b o76=%b s76=%b want 0 0 1 1",
                     tr_out[67][3], tr_out[75][3], tr_out[76][3], tr_stb[76][3]);
        end
    endtask

    task automatic test_phase();
        int   mc;
        logic e;
        cfg_write(2'd0, 3'd0, 16'd25);
        cfg_write(2'd1, 3'd0, 16'd12);
        cfg_write(2'd2, 3'd0, 16'd0);
        set_model(0, 25, 12, 0);
        clear_sched();
        step_sched[5] = 1'b1;
        step_sched[20] = 1'b1;
        step_sched[22] = 1'b1;
        step_sched[24] = 1'b1;
        step_sched[30] = 1'b1; stepch_sched[30] = 3'd5;
        capture(60, 1'b1);
        mc = 0;
        for (int j = 0; j < 60; j++) begin
            e = (j >= 1) && (mc < 12);
            if (j >= 1 && !(DYN && step_sched[j] && stepch_sched[j] == 3'd0 && j >= 17))
                mc = (mc + 1) % 25;
            checks++;
            if (tr_out[j][0] !== e) begin
                errors++;
                $display("FAIL phase_ch0 j=%0d got %b want %b", j, tr_out[j][0], e);
            end
            for (int c = 1; c < NC; c++) begin
                checks++;
                if (tr_out[j][c] !== exp_bit(c, j)) begin
                    errors++;
                    $display("FAIL phase_other j=%0d ch=%0d got %b want %b", j, c, tr_out[j][c], exp_bit(c, j));
                end
            end
            checks++;
            if (tr_done[j] !== (DYN && step_sched[j])) begin
                errors++;
                $display("FAIL phase_done j=%0d got %b want %b", j, tr_done[j], (DYN && step_sched[j]));
            end
            checks++;
            if (tr_lk[j] !== (j >= 16)) begin
                errors++;
                $display("FAIL phase_locked j=%0d got %b want %b", j, tr_lk[j], (j >= 16));
            end
        end
        checks++;
        if (tr_out[26][0] !== !DYN || tr_out[28][0] !== !DYN || tr_out[29][0] !== 1'b1) begin
            errors++;
            $display("FAIL phase_shift got o26=%b o28=%b o29=%b want %b %b 1",
                     tr_out[26][0], tr_out[28][0], tr_out[29][0], !DYN, !DYN);
        end
    endtask

    task automatic test_async_reset();
        bit found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            if (outclk !== '0) found = 1'b1;
            else @(negedge refclk);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL arst_wait got outclk=%b want nonzero within 30 cycles", outclk);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (outclk !== '0 || outclk_stb !== '0 || locked !== 1'b0 || phase_done !== 1'b0) begin
            errors++;
            $display("FAIL arst_immediate got out=%b stb=%b lk=%b done=%b want all 0",
                     outclk, outclk_stb, locked, phase_done);
        end
        @(negedge refclk);
        for (int c = 0; c < NC; c++) set_model(c, 25, 12, 0);
        clear_sched();
        rst = 1'b0;
        capture(30, 1'b0);
        for (int j = 0; j < 30; j++) begin
            for (int c = 0; c < NC; c++) begin
                checks++;
                if (tr_out[j][c] !== exp_bit(c, j)) begin
                    errors++;
                    $display("FAIL arst_wave j=%0d ch=%0d got %b want %b", j, c, tr_out[j][c], exp_bit(c, j));
                end
            end
            checks++;
            if (tr_lk[j] !== (j >= 16)) begin
                errors++;
                $display("FAIL arst_locked j=%0d got %b want %b", j, tr_lk[j], (j >= 16));
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        cfg_wr     = 1'b0;
        cfg_apply  = 1'b0;
        cfg_sel    = 2'd0;
        cfg_ch     = '0;
        cfg_data   = '0;
        outclk_en  = '1;
        phase_step = 1'b0;
        phase_updn = 1'b0;
        phase_ch   = '0;
        test_reset();
        test_program();
        test_clamp();
        test_write_through();
        test_gate();
        test_phase();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
